rom_sdram_writer: RTL and testbench

- Sits directly downstream of the ROM loader dispatcher.
- Consumes its word address, data and nine per-region write strobes, and maps each strobe to a fixed SDRAM region.
- Buffers writes in a small FIFO and issues them to the SDRAM controller over a req/ack handshake.
- Backpressures the HPS download with ioctl_wait and reports when all loaded words have been committed.

---
 rtl/rom_sdram_writer.sv | 196 +++++++++++++++++++
 tb/tb_rom_sdram_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sdram_writer.sv
// rom_sdram_writer: maps ROM loader writes onto fixed SDRAM regions, buffers
// them in a small FIFO and issues them to the SDRAM controller over req/ack.
// Optional feature macro: ROM_CHECKSUM_EN (adds a 16-bit sum of committed words).
module rom_sdram_writer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned REGION_BITS = 20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load_en,
  input  logic [8:0]  rom_we,
  input  logic [25:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        ioctl_wait,
  output logic        sdram_req,
  output logic [23:0] sdram_addr,
  output logic [15:0] sdram_data,
  input  logic        sdram_ack,
  output logic        load_done,
`ifdef ROM_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WE_W   = 9;
  localparam int unsigned IDX_W  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  wr_entry_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic [IDX_W-1:0]  region_idx;
  wr_entry_t         in_entry;
  logic              strobe;
  logic              full;
  logic              push;
  logic              drop;
  logic              pop;

  logic              load_en_q;
  logic              load_rise;
  logic              seen_load;

  // Address bits above the region window are intentionally discarded.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^rom_addr[25:REGION_BITS];

  // Lowest set write strobe selects the region; higher bits are ignored.
  always_comb begin
    region_idx = '0;
    for (int i = WE_W - 1; i >= 0; i--) begin
      if (rom_we[i]) region_idx = IDX_W'(i);
    end
  end

  // Incoming FIFO entry and push/drop qualification.
  always_comb begin
    in_entry.addr = ADDR_W'({region_idx, rom_addr[REGION_BITS-1:0]});
    in_entry.data = rom_data;
    strobe        = |rom_we;
    full          = (count == CNT_W'(FIFO_DEPTH));
    push          = strobe && !full;
    drop          = strobe && full;
  end

  // Write FSM next state and FIFO pop decision.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this edge; a push and pop together cancel out.
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign load_rise = load_en && !load_en_q;

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // Registered SDRAM request, payload, backpressure and overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sdram_req <= (state_next == ST_REQ);
      if (pop) begin
        sdram_addr <= mem[rd_ptr].addr;
        sdram_data <= mem[rd_ptr].data;
      end
      // Stall one slot early so a strobe already in flight still fits.
      ioctl_wait <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
      if (drop) overflow <= 1'b1;
    end
  end

  // Download tracking and completion flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_en_q <= 1'b0;
      seen_load <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_en_q <= load_en;
      if (load_rise) seen_load <= 1'b1;
      if (load_rise) begin
        load_done <= 1'b0;
      end else begin
        load_done <= seen_load && !load_en && (count == '0) && (state == ST_IDLE);
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  // Running sum of every word the SDRAM controller acknowledges.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum <= '0;
    end else if (load_rise) begin
      checksum <= '0;
    end else if (state == ST_REQ && sdram_ack) begin
      checksum <= checksum + sdram_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_sdram_writer.sv
// Directed bench for rom_sdram_writer with hand-computed expectations.
module tb_rom_sdram_writer;

  logic        clk_sys;
  logic        reset;
  logic        load_en;
  logic [8:0]  rom_we;
  logic [25:0] rom_addr;
  logic [15:0] rom_data;
  logic        ioctl_wait;
  logic        sdram_req;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_data;
  logic        sdram_ack;
  logic        load_done;
  logic        overflow;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int total;
  int bad;

  rom_sdram_writer #(
    .FIFO_DEPTH (4),
    .REGION_BITS(20)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .load_en   (load_en),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ioctl_wait(ioctl_wait),
    .sdram_req (sdram_req),
    .sdram_addr(sdram_addr),
    .sdram_data(sdram_data),
    .sdram_ack (sdram_ack),
    .load_done (load_done),
`ifdef ROM_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .overflow  (overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [8:0] we, input logic [25:0] a, input logic [15:0] d);
    rom_we   = we;
    rom_addr = a;
    rom_data = d;
  endtask

  initial begin
    int i;
    int k;
    logic seen_wait;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    rom_we    = '0;
    rom_addr  = '0;
    rom_data  = '0;
    sdram_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_data", 32'(sdram_data), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single write into region 2 (tiles)
    load_en = 1'b1;
    strobe(9'h004, 26'h0000123, 16'hBEEF);
    tick();
    strobe(9'h000, 26'h0, 16'h0);
    check("single_req_e0", 32'(sdram_req), 32'd0);
    tick();
    check("single_req", 32'(sdram_req), 32'd1);
    check("single_addr", 32'(sdram_addr), 32'h200123);
    check("single_data", 32'(sdram_data), 32'hBEEF);
    tick();
    tick();
    check("single_hold", 32'(sdram_req), 32'd1);
    check("single_hold_addr", 32'(sdram_addr), 32'h200123);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("single_req_drop", 32'(sdram_req), 32'd0);

    // Priority: bits 6 and 7 set, lowest wins (prom1)
    strobe(9'h0C0, 26'h5, 16'h1234);
    tick();
    strobe(9'h000, 26'h0, 16'h0);
    tick();
    check("prio_addr", 32'(sdram_addr), 32'h600005);
    check("prio_data", 32'(sdram_data), 32'h1234);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;

    // Region 8 with all-ones address: upper address bits discarded
    strobe(9'h100, 26'h3FFFFFF, 16'h7759);
    tick();
    strobe(9'h000, 26'h0, 16'h0);
    tick();
    check("r8_addr", 32'(sdram_addr), 32'h8FFFFF);
    check("r8_data", 32'(sdram_data), 32'h7759);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("r8_idle", 32'(sdram_req), 32'd0);

    // Burst of 8 with ack withheld; source honours ioctl_wait
    i = 0;
    seen_wait = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ioctl_wait) seen_wait = 1'b1;
      if (i < 8 && !ioctl_wait) begin
        strobe(9'h001, 26'(i), 16'h1000 + 16'(i));
        i++;
      end else begin
        strobe(9'h000, 26'h0, 16'h0);
      end
      tick();
    end
    check("burst_seen_wait", 32'(seen_wait), 32'd1);
    check("burst_wait_now", 32'(ioctl_wait), 32'd1);
    check("burst_accepted", 32'(i), 32'd4);
    check("burst_ovf", 32'(overflow), 32'd0);
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      if (sdram_req) begin
        check("burst_data", 32'(sdram_data), 32'h1000 + 32'(k));
        check("burst_addr", 32'(sdram_addr), 32'(k));
        k++;
        sdram_ack = 1'b1;
      end else begin
        sdram_ack = 1'b0;
      end
      if (i < 8 && !ioctl_wait) begin
        strobe(9'h001, 26'(i), 16'h1000 + 16'(i));
        i++;
      end else begin
        strobe(9'h000, 26'h0, 16'h0);
      end
      tick();
    end
    sdram_ack = 1'b0;
    strobe(9'h000, 26'h0, 16'h0);
    check("burst_words", 32'(k), 32'd8);
    check("burst_ovf_end", 32'(overflow), 32'd0);
    tick();
    check("burst_idle", 32'(sdram_req), 32'd0);

    // Overflow: six pushes with no ack, ioctl_wait ignored
    for (int n = 0; n < 6; n++) begin
      strobe(9'h008, 26'(n), 16'hC000 + 16'(n));
      tick();
      if (n == 4) check("ovf_before", 32'(overflow), 32'd0);
    end
    strobe(9'h000, 26'h0, 16'h0);
    check("ovf_set", 32'(overflow), 32'd1);
    tick();
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    load_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_rst_req", 32'(sdram_req), 32'd0);

    // Completion: two words, load_en dropped while the second is pending
    tick();
    check("done_no_load", 32'(load_done), 32'd0);
    load_en = 1'b1;
    strobe(9'h002, 26'h10, 16'hAAAA);
    tick();
    strobe(9'h002, 26'h11, 16'h5555);
    tick();
    strobe(9'h000, 26'h0, 16'h0);
    load_en = 1'b0;
    check("done_w0_addr", 32'(sdram_addr), 32'h100010);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("done_w1_req", 32'(sdram_req), 32'd1);
    check("done_w1_data", 32'(sdram_data), 32'h5555);
    tick();
    tick();
    check("done_pending", 32'(load_done), 32'd0);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("done_at_ack", 32'(load_done), 32'd0);
    tick();
    check("done_set", 32'(load_done), 32'd1);
`ifdef ROM_CHECKSUM_EN
    check("done_checksum", 32'(checksum), 32'hFFFF);
`endif
    load_en = 1'b1;
    tick();
    check("done_cleared", 32'(load_done), 32'd0);

    // Reset while a request is outstanding with two entries queued
    strobe(9'h008, 26'h7, 16'h0001);
    tick();
    strobe(9'h008, 26'h8, 16'h0002);
    tick();
    strobe(9'h008, 26'h9, 16'h0003);
    tick();
    strobe(9'h000, 26'h0, 16'h0);
    check("mid_req", 32'(sdram_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_req", 32'(sdram_req), 32'd0);
    check("mid_rst_addr", 32'(sdram_addr), 32'd0);
    check("mid_rst_data", 32'(sdram_data), 32'd0);
    check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    check("mid_stray_ack", 32'(sdram_req), 32'd0);

`ifdef ROM_CHECKSUM_EN
    // Checksum wraps modulo 2^16
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    strobe(9'h001, 26'h0, 16'hFFFF);
    tick();
    strobe(9'h001, 26'h1, 16'h0002);
    tick();
    strobe(9'h000, 26'h0, 16'h0);
    for (int c = 0; c < 10; c++) begin
      sdram_ack = sdram_req;
      tick();
    end
    sdram_ack = 1'b0;
    check("cksum_wrap", 32'(checksum), 32'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
